// File: rtl/rram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rram_pkg
// Purpose  : Shared types and helpers for the RRAM matrix-vector readout block.
//            Holds the controller state encoding, OPCODE field positions and
//            the accumulator-width / elements-per-beat derivations.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CONV    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int OPCODE_WIDTH = 18;
  localparam int OP_FIELD_W   = 4;
  localparam int OP_NBITS_LSB = 0;   // nbits-1
  localparam int OP_WAYS_LSB  = 4;   // ways-1

  // Shift-add over MAX_IN_BITS planes of ADC_BITS codes never exceeds this.
  function automatic int acc_width(input int adc_bits, input int max_in_bits);
    return adc_bits + max_in_bits;
  endfunction

  function automatic int per_beat(input int dataout_width, input int acc_w);
    return dataout_width / acc_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rram_mvm_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : rram_mvm_readout_if
// Purpose  : Command and result-stream handshake bundle of rram_mvm_readout.
// Ports    : valid_i/ready_o/OPCODE  - command handshake
//            valid_o/ready_i/DATAOUT - packed accumulator output stream
//            master modport = requester/consumer, slave modport = readout block
// Revision : 1.0 - initial release
// ============================================================================
interface rram_mvm_readout_if #(
  parameter int DATAOUT_WIDTH = 64
);
  import rram_pkg::*;

  logic                     valid_i;
  logic                     ready_o;
  logic [OPCODE_WIDTH-1:0]  OPCODE;
  logic                     valid_o;
  logic                     ready_i;
  logic [DATAOUT_WIDTH-1:0] DATAOUT;

  modport master (
    output valid_i, OPCODE, ready_i,
    input  ready_o, valid_o, DATAOUT
  );

  modport slave (
    input  valid_i, OPCODE, ready_i,
    output ready_o, valid_o, DATAOUT
  );

endinterface
`default_nettype wire

// File: rtl/rram_acc_bank.sv
`default_nettype none
// ============================================================================
// Module   : rram_acc_bank
// Purpose  : Accumulator array, one entry per (way, ADC). Element index is
//            way*NUM_ADC + adc. Supports bulk clear, MSB-first shift-add of a
//            full ADC row into the selected way, and RD_PORTS consecutive
//            read ports starting at rd_base (entries at or past rd_limit read 0).
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            clr           - clear all accumulators
//            en, way       - shift-add adc_codes into row 'way'
//            adc_codes     - NUM_ADC packed unsigned codes
//            rd_base/limit - first element and element count for the read port
//            rd_data       - RD_PORTS packed accumulators
// Revision : 1.0 - initial release
// ============================================================================
module rram_acc_bank #(
  parameter int NUM_ADC   = 32,
  parameter int MUX_WAYS  = 16,
  parameter int ADC_BITS  = 4,
  parameter int ACC_WIDTH = 12,
  parameter int RD_PORTS  = 5,
  parameter int IDX_W     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic [$clog2(MUX_WAYS)-1:0]   way,
  input  logic [NUM_ADC*ADC_BITS-1:0]   adc_codes,
  input  logic [IDX_W-1:0]              rd_base,
  input  logic [IDX_W-1:0]              rd_limit,
  output logic [RD_PORTS*ACC_WIDTH-1:0] rd_data
);

  localparam int WAY_W    = $clog2(MUX_WAYS);
  localparam int NUM_ELEM = MUX_WAYS * NUM_ADC;
  localparam int EIDX_W   = $clog2(NUM_ELEM);

  logic [ACC_WIDTH-1:0] acc [NUM_ELEM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NUM_ELEM; e++) acc[e] <= '0;
    end else if (clr) begin
      for (int e = 0; e < NUM_ELEM; e++) acc[e] <= '0;
    end else if (en) begin
      for (int w = 0; w < MUX_WAYS; w++) begin
        if (way == WAY_W'(w)) begin
          for (int a = 0; a < NUM_ADC; a++) begin
            acc[w*NUM_ADC + a] <= (acc[w*NUM_ADC + a] << 1)
                                + ACC_WIDTH'(adc_codes[a*ADC_BITS +: ADC_BITS]);
          end
        end
      end
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] val;
    always_comb begin
      idx = rd_base + IDX_W'(k);
      val = '0;
      // Past the end of the command's elements the lane is zero-padded.
      if (idx < rd_limit) val = acc[idx[EIDX_W-1:0]];
    end
    assign rd_data[k*ACC_WIDTH +: ACC_WIDTH] = val;
  end

endmodule
`default_nettype wire

// File: rtl/rram_mvm_readout.sv
`default_nettype none
// ============================================================================
// Module   : rram_mvm_readout
// Purpose  : Bit-serial RRAM MVM readout sequencer. For every input bit-plane
//            (MSB first) and every SL way it settles the mux, fires the shared
//            ADCs, shift-adds the codes into per-(way, ADC) accumulators, then
//            streams all accumulators out PER_BEAT per DATAOUT beat.
// Ports    : CLK, RST    - clock, asynchronous active-high reset
//            bus         - command (valid_i/ready_o/OPCODE) and result stream
//                          (valid_o/ready_i/DATAOUT)
//            SL_MUX_SEL  - one-hot SL select, 0 when not converting
//            IN_BIT      - bit-plane index driven onto the WLs
//            ADC_START   - one-cycle conversion pulse
//            ADCOUT      - NUM_ADC unsigned ADC codes
//            busy        - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module rram_mvm_readout
  import rram_pkg::*;
#(
  parameter int NUM_ADC       = 32,
  parameter int ADC_BITS      = 4,
  parameter int MUX_WAYS      = 16,
  parameter int MAX_IN_BITS   = 8,
  parameter int ADC_LAT       = 3,
  parameter int SETTLE_CYC    = 2,
  parameter int DATAOUT_WIDTH = 64
) (
  input  logic                             CLK,
  input  logic                             RST,
  rram_mvm_readout_if.slave                bus,
  output logic [MUX_WAYS-1:0]              SL_MUX_SEL,
  output logic [$clog2(MAX_IN_BITS)-1:0]   IN_BIT,
  output logic                             ADC_START,
  input  logic [NUM_ADC*ADC_BITS-1:0]      ADCOUT,
  output logic                             busy
);

  localparam int ACC_WIDTH = acc_width(ADC_BITS, MAX_IN_BITS);
  localparam int PER_BEAT  = per_beat(DATAOUT_WIDTH, ACC_WIDTH);
  localparam int BIT_W     = $clog2(MAX_IN_BITS);
  localparam int WAY_W     = $clog2(MUX_WAYS);
  localparam int NUM_ELEM  = MUX_WAYS * NUM_ADC;
  // Wide enough to hold elem + PER_BEAT without wrapping.
  localparam int ELEM_W    = $clog2(NUM_ELEM + PER_BEAT + 1);
  localparam int CNT_MAX   = (SETTLE_CYC > ADC_LAT) ? SETTLE_CYC : ADC_LAT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [WAY_W-1:0]   ways_m1_q, ways_m1_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ELEM_W-1:0]  elem_q, elem_d;

  logic                          acc_clr, acc_en;
  logic [ELEM_W-1:0]             total_elems;
  logic [PER_BEAT*ACC_WIDTH-1:0] rd_data;
  int                            nbits_req, ways_req;

  logic ready, out_valid;
  logic [DATAOUT_WIDTH-1:0] dataout;

  // OPCODE bits above the two fields carry no meaning here.
  logic unused_opcode;
  assign unused_opcode = ^bus.OPCODE[OPCODE_WIDTH-1:OP_WAYS_LSB+OP_FIELD_W];

  assign total_elems = ({{(ELEM_W-WAY_W){1'b0}}, ways_m1_q} + ELEM_W'(1)) * ELEM_W'(NUM_ADC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ways_m1_q <= '0;
      way_q     <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      elem_q    <= '0;
    end else begin
      state_q   <= state_d;
      ways_m1_q <= ways_m1_d;
      way_q     <= way_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      elem_q    <= elem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ways_m1_d  = ways_m1_q;
    way_d      = way_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    elem_d     = elem_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    nbits_req  = int'(bus.OPCODE[OP_NBITS_LSB +: OP_FIELD_W]);
    ways_req   = int'(bus.OPCODE[OP_WAYS_LSB +: OP_FIELD_W]);
    ready      = 1'b0;
    out_valid  = 1'b0;
    ADC_START  = 1'b0;
    SL_MUX_SEL = '0;
    IN_BIT     = '0;
    dataout    = '0;

    // Requests beyond the hardware are clamped to the largest supported size.
    if (ways_req > MUX_WAYS - 1)     ways_req  = MUX_WAYS - 1;
    if (nbits_req > MAX_IN_BITS - 1) nbits_req = MAX_IN_BITS - 1;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_i) begin
          ways_m1_d = WAY_W'(ways_req);
          bit_d     = BIT_W'(nbits_req);
          way_d     = '0;
          cnt_d     = '0;
          elem_d    = '0;
          acc_clr   = 1'b1;
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        SL_MUX_SEL = MUX_WAYS'(1) << way_q;
        IN_BIT     = bit_q;
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = CONV;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CONV: begin
        SL_MUX_SEL = MUX_WAYS'(1) << way_q;
        IN_BIT     = bit_q;
        ADC_START  = (cnt_q == '0);
        if (cnt_q == CNT_W'(ADC_LAT - 1)) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CAPTURE: begin
        SL_MUX_SEL = MUX_WAYS'(1) << way_q;
        IN_BIT     = bit_q;
        acc_en     = 1'b1;
        cnt_d      = '0;
        if (way_q != ways_m1_q) begin
          way_d   = way_q + WAY_W'(1);
          state_d = SETTLE;
        end else if (bit_q != '0) begin
          way_d   = '0;
          bit_d   = bit_q - BIT_W'(1);
          state_d = SETTLE;
        end else begin
          elem_d  = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        dataout[PER_BEAT*ACC_WIDTH-1:0] = rd_data;
        if (bus.ready_i) begin
          if (elem_q + ELEM_W'(PER_BEAT) >= total_elems) begin
            elem_d  = '0;
            state_d = IDLE;
          end else begin
            elem_d = elem_q + ELEM_W'(PER_BEAT);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = out_valid;
  assign bus.DATAOUT = dataout;
  assign busy        = (state_q != IDLE);

  rram_acc_bank #(
    .NUM_ADC  (NUM_ADC),
    .MUX_WAYS (MUX_WAYS),
    .ADC_BITS (ADC_BITS),
    .ACC_WIDTH(ACC_WIDTH),
    .RD_PORTS (PER_BEAT),
    .IDX_W    (ELEM_W)
  ) u_acc_bank (
    .clk      (CLK),
    .rst      (RST),
    .clr      (acc_clr),
    .en       (acc_en),
    .way      (way_q),
    .adc_codes(ADCOUT),
    .rd_base  (elem_q),
    .rd_limit (total_elems),
    .rd_data  (rd_data)
  );

endmodule
`default_nettype wire
